// File: rtl/vs_omp_sequencer.sv
// Iteration controller for OMP-style greedy sparse recovery. It drives the sensing-matrix
// processor and the batched max identifier, keeps the support list and hands off to residual update.
module vs_omp_sequencer #(
  parameter int COLUMNS    = 256,
  parameter int BATCH_SIZE = 64,
  parameter int K          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        load_matrix,
  input  logic [7:0]  sparsity,
  input  logic [31:0] threshold,
  output logic        busy,
  output logic        done,
  output logic [1:0]  stop_reason,
  output logic [7:0]  iteration,
  output logic [1:0]  smp_command,
  output logic        smp_start,
  input  logic        smp_done,
  output logic        max_reset_n,
  output logic        max_start,
  input  logic        max_batch_done,
  input  logic [7:0]  max_location,
  input  logic [31:0] max_value,
  output logic        support_write_enable,
  output logic [7:0]  support_write_addr,
  output logic [7:0]  support_write_data,
  output logic        res_start,
  input  logic        res_done
);
  localparam int BATCHES = COLUMNS / BATCH_SIZE;
  localparam int BCW     = (BATCHES > 1) ? $clog2(BATCHES) : 1;
  localparam int SW      = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] CMD_LOAD     = 2'd0;
  localparam logic [1:0] CMD_COMPUTE  = 2'd1;
  localparam logic [1:0] SR_SPARSITY  = 2'd0;
  localparam logic [1:0] SR_THRESHOLD = 2'd1;
  localparam logic [1:0] SR_DUPLICATE = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOAD_WAIT, S_IP, S_IP_WAIT, S_MAX,
    S_MAX_WAIT, S_DECIDE, S_RES, S_RES_WAIT, S_FINISH
  } state_t;

  // Sign-magnitude IEEE-754 compare a <= b; +0 and -0 are equal, NaN is not handled.
  function automatic logic fp_le(input logic [31:0] a, input logic [31:0] b);
    logic r;
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) r = 1'b1;
    else if (a[31] != b[31])                       r = a[31];
    else if (a[31])                                r = (a[30:0] >= b[30:0]);
    else                                           r = (a[30:0] <= b[30:0]);
    return r;
  endfunction

  state_t           r_state, w_next;
  logic             r_busy, r_done, r_smp_start, r_max_reset_n, r_max_start, r_we, r_res_start;
  logic [1:0]       r_stop, r_cmd;
  logic [7:0]       r_iter, r_addr, r_data, r_kmax;
  logic [BCW-1:0]   r_batch;
  logic [7:0]       r_support [K];

  logic             w_busy, w_done, w_smp_start, w_max_reset_n, w_max_start, w_we, w_res_start, w_clear;
  logic [1:0]       w_stop, w_cmd;
  logic [7:0]       w_iter, w_addr, w_data, w_kmax, w_kmax_in, w_iter_inc;
  logic [BCW-1:0]   w_batch;
  logic             w_below, w_dup, w_last_batch;

  assign w_kmax_in    = (sparsity > 8'(K)) ? 8'(K) : sparsity;
  assign w_iter_inc   = r_iter + 8'd1;
  assign w_below      = fp_le(max_value, threshold);
  assign w_last_batch = (r_batch == BCW'(BATCHES - 1));

  // Duplicate detection against the entries selected so far in this run.
  always_comb begin
    w_dup = 1'b0;
    for (int j = 0; j < K; j++) begin
      w_dup = w_dup | ((j < int'(r_iter)) && (r_support[j] == max_location));
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; handshake inputs only matter in their wait state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = !start ? S_IDLE : (w_kmax_in == 8'd0) ? S_FINISH : (load_matrix ? S_LOAD : S_IP);
      S_LOAD:      w_next = S_LOAD_WAIT;
      S_LOAD_WAIT: w_next = smp_done ? S_IP : S_LOAD_WAIT;
      S_IP:        w_next = S_IP_WAIT;
      S_IP_WAIT:   w_next = smp_done ? S_MAX : S_IP_WAIT;
      S_MAX:       w_next = S_MAX_WAIT;
      S_MAX_WAIT:  w_next = !max_batch_done ? S_MAX_WAIT : (w_last_batch ? S_DECIDE : S_MAX);
      S_DECIDE:    w_next = (w_below || w_dup) ? S_FINISH : S_RES;
      S_RES:       w_next = S_RES_WAIT;
      S_RES_WAIT:  w_next = !res_done ? S_RES_WAIT : ((w_iter_inc == r_kmax) ? S_FINISH : S_IP);
      S_FINISH:    w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Strobes follow the state being entered.
  always_comb begin
    w_busy        = r_busy;
    w_done        = 1'b0;
    w_stop        = r_stop;
    w_iter        = r_iter;
    w_kmax        = r_kmax;
    w_smp_start   = (w_next == S_LOAD) || (w_next == S_IP);
    w_max_start   = (w_next == S_MAX);
    w_res_start   = (w_next == S_RES);
    w_max_reset_n = !((w_next == S_IDLE) || (w_next == S_IP));
    w_we          = 1'b0;
    w_addr        = r_addr;
    w_data        = r_data;
    w_batch       = r_batch;
    w_clear       = 1'b0;
    if (w_next == S_LOAD)    w_cmd = CMD_LOAD;
    else if (w_next == S_IP) w_cmd = CMD_COMPUTE;
    else                     w_cmd = r_cmd;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_busy  = 1'b1;
          w_iter  = 8'd0;
          w_clear = 1'b1;
          w_kmax  = w_kmax_in;
          w_stop  = (w_kmax_in == 8'd0) ? SR_SPARSITY : r_stop;
        end else begin
          w_busy  = r_busy;
        end
      end
      S_IP:       w_batch = BCW'(0);
      S_MAX_WAIT: w_batch = max_batch_done ? (r_batch + BCW'(1)) : r_batch;
      S_DECIDE: begin
        if (w_below)    w_stop = SR_THRESHOLD;
        else if (w_dup) w_stop = SR_DUPLICATE;
        else begin
          w_we   = 1'b1;
          w_addr = r_iter;
          w_data = max_location;
        end
      end
      S_RES_WAIT: begin
        if (res_done) begin
          w_iter = w_iter_inc;
          w_stop = (w_iter_inc == r_kmax) ? SR_SPARSITY : r_stop;
        end else begin
          w_iter = r_iter;
        end
      end
      S_FINISH: begin
        w_busy = 1'b0;
        w_done = 1'b1;
      end
      default: w_busy = r_busy;
    endcase
  end

  // Output and datapath registers, including the internal support list.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_stop        <= SR_SPARSITY;
      r_iter        <= 8'd0;
      r_kmax        <= 8'd0;
      r_cmd         <= CMD_COMPUTE;
      r_smp_start   <= 1'b0;
      r_max_reset_n <= 1'b0;
      r_max_start   <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= 8'd0;
      r_data        <= 8'd0;
      r_res_start   <= 1'b0;
      r_batch       <= BCW'(0);
      for (int j = 0; j < K; j++) r_support[j] <= 8'd0;
    end else begin
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_stop        <= w_stop;
      r_iter        <= w_iter;
      r_kmax        <= w_kmax;
      r_cmd         <= w_cmd;
      r_smp_start   <= w_smp_start;
      r_max_reset_n <= w_max_reset_n;
      r_max_start   <= w_max_start;
      r_we          <= w_we;
      r_addr        <= w_addr;
      r_data        <= w_data;
      r_res_start   <= w_res_start;
      r_batch       <= w_batch;
      if (w_clear) begin
        for (int j = 0; j < K; j++) r_support[j] <= 8'd0;
      end else if (w_we) begin
        r_support[r_iter[SW-1:0]] <= max_location;
      end
    end
  end

  assign busy                 = r_busy;
  assign done                 = r_done;
  assign stop_reason          = r_stop;
  assign iteration            = r_iter;
  assign smp_command          = r_cmd;
  assign smp_start            = r_smp_start;
  assign max_reset_n          = r_max_reset_n;
  assign max_start            = r_max_start;
  assign support_write_enable = r_we;
  assign support_write_addr   = r_addr;
  assign support_write_data   = r_data;
  assign res_start            = r_res_start;
endmodule

// File: tb/tb_vs_omp_sequencer.sv
// Self-checking bench for vs_omp_sequencer: stub processor/max/residual responders, a run-level
// model of the OMP loop built from real-valued float compares, and a per-cycle event monitor.
module tb_vs_omp_sequencer;
  localparam logic [1:0] CMD_LOAD    = 2'd0;
  localparam logic [1:0] CMD_COMPUTE = 2'd1;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, load_matrix = 1'b0;
  logic [7:0] sparsity = 8'd0;
  logic [31:0] threshold = 32'd0;
  logic busy, done, smp_start, max_reset_n, max_start, support_write_enable, res_start;
  logic [1:0] stop_reason, smp_command;
  logic [7:0] iteration, support_write_addr, support_write_data;
  logic smp_done = 1'b0, max_batch_done = 1'b0, res_done = 1'b0;
  logic [7:0] max_location = 8'd0;
  logic [31:0] max_value = 32'd0;

  vs_omp_sequencer #(.COLUMNS(256), .BATCH_SIZE(64), .K(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .load_matrix(load_matrix),
    .sparsity(sparsity), .threshold(threshold), .busy(busy), .done(done),
    .stop_reason(stop_reason), .iteration(iteration), .smp_command(smp_command),
    .smp_start(smp_start), .smp_done(smp_done), .max_reset_n(max_reset_n),
    .max_start(max_start), .max_batch_done(max_batch_done), .max_location(max_location),
    .max_value(max_value), .support_write_enable(support_write_enable),
    .support_write_addr(support_write_addr), .support_write_data(support_write_data),
    .res_start(res_start), .res_done(res_done));

  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;
  logic [7:0]  tbl_loc [16];
  logic [31:0] tbl_val [16];
  logic [1:0]  exp_cmd_q [$];
  logic [15:0] exp_wr_q [$];
  int exp_n_max, exp_n_res, exp_iter, exp_stop;
  int cnt_max, cnt_res, cnt_smp, cur_ip;
  logic [15:0] wr_log [16];
  int wr_log_n;
  bit run_active = 1'b0;
  int max_dmin = 1, max_dmax = 3;
  bit spur_en = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  function automatic real f2r(input logic [31:0] b);
    real m;
    int e;
    e = int'(b[30:23]);
    m = real'(b[22:0]) / 8388608.0;
    if (e == 0) m = m * (2.0 ** (-126));
    else        m = (1.0 + m) * (2.0 ** (e - 127));
    return b[31] ? -m : m;
  endfunction

  // Run-level model: walk the OMP loop over the stub's per-iteration (location, value) table.
  task automatic compute_model(input bit ld, input int sp, input logic [31:0] thr);
    int kmax, it;
    bit dup;
    logic [7:0] sel [$];
    exp_cmd_q.delete();
    exp_wr_q.delete();
    kmax = (sp > 8) ? 8 : sp;
    it = 0;
    exp_stop = 0;
    exp_n_max = 0;
    if (kmax > 0) begin
      if (ld) exp_cmd_q.push_back(CMD_LOAD);
      for (int g = 0; g < 16; g++) begin
        exp_cmd_q.push_back(CMD_COMPUTE);
        exp_n_max += 4;
        if (f2r(tbl_val[it]) <= f2r(thr)) begin exp_stop = 1; break; end
        dup = 1'b0;
        foreach (sel[s]) if (sel[s] == tbl_loc[it]) dup = 1'b1;
        if (dup) begin exp_stop = 2; break; end
        sel.push_back(tbl_loc[it]);
        exp_wr_q.push_back({it[7:0], tbl_loc[it]});
        it++;
        if (it == kmax) begin exp_stop = 0; break; end
      end
    end
    exp_iter = it;
    exp_n_res = it;
  endtask

  // Processor stub: done 1..4 cycles after smp_start, sometimes a premature done in the start cycle.
  initial begin
    int c = 0;
    forever begin
      @(negedge clock);
      smp_done = 1'b0;
      if (!reset_n) c = 0;
      else if (smp_start) begin
        c = $urandom_range(1, 4);
        if (spur_en && ($urandom_range(0, 1) == 1)) smp_done = 1'b1;
      end else if (c > 0) begin
        c--;
        if (c == 0) smp_done = 1'b1;
      end
    end
  end

  // Max identifier stub: batch done after a delay, presenting this iteration's arg-max.
  initial begin
    int c = 0;
    int idx;
    forever begin
      @(negedge clock);
      max_batch_done = 1'b0;
      if (!reset_n) c = 0;
      else if (max_start) c = $urandom_range(max_dmin, max_dmax);
      else if (c > 0) begin
        c--;
        if (c == 0) begin
          idx = (cur_ip > 0) ? ((cur_ip - 1) & 15) : 0;
          max_location = tbl_loc[idx];
          max_value = tbl_val[idx];
          max_batch_done = 1'b1;
        end
      end
    end
  end

  // Residual stub, with the same premature-done behaviour as the processor stub.
  initial begin
    int c = 0;
    forever begin
      @(negedge clock);
      res_done = 1'b0;
      if (!reset_n) c = 0;
      else if (res_start) begin
        c = $urandom_range(1, 4);
        if (spur_en && ($urandom_range(0, 1) == 1)) res_done = 1'b1;
      end else if (c > 0) begin
        c--;
        if (c == 0) res_done = 1'b1;
      end
    end
  end

  // Compare process: checks every strobe against the model's expected event streams.
  initial begin
    logic p_smp = 1'b0, p_max = 1'b0, p_res = 1'b0, p_we = 1'b0, p_done = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (smp_start) begin
          cnt_smp++;
          chk("smp_start_width", p_smp, 0);
          if (exp_cmd_q.size() == 0) chk("smp_start_unexpected", 1, 0);
          else chk("smp_command", smp_command, exp_cmd_q.pop_front());
          if (smp_command == CMD_COMPUTE) begin
            cur_ip++;
            chk("max_reset_n_low_in_ip", max_reset_n, 0);
          end
        end
        if (max_start) begin
          cnt_max++;
          chk("max_start_width", p_max, 0);
          chk("max_reset_n_high_at_max_start", max_reset_n, 1);
        end
        if (res_start) begin
          cnt_res++;
          chk("res_start_width", p_res, 0);
        end
        if (support_write_enable) begin
          chk("support_we_width", p_we, 0);
          if (wr_log_n < 16) wr_log[wr_log_n] = {support_write_addr, support_write_data};
          wr_log_n++;
          if (exp_wr_q.size() == 0) chk("support_write_unexpected", support_write_addr, 255);
          else chk("support_write_addr_data", {support_write_addr, support_write_data}, exp_wr_q.pop_front());
        end
        if (done) begin
          chk("done_width", p_done, 0);
          if (!run_active) chk("done_unexpected", 1, 0);
          else begin
            chk("stop_reason", stop_reason, exp_stop);
            chk("iteration", iteration, exp_iter);
            chk("busy_low_at_done", busy, 0);
            chk("max_start_count", cnt_max, exp_n_max);
            chk("res_start_count", cnt_res, exp_n_res);
            chk("cmd_queue_drained", exp_cmd_q.size(), 0);
            chk("write_queue_drained", exp_wr_q.size(), 0);
          end
        end
      end
      p_smp = smp_start; p_max = max_start; p_res = res_start; p_we = support_write_enable; p_done = done;
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset_n = 1'b0;
    start = 1'b0;
    repeat (cycles) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_strobes"}, {smp_start, max_start, support_write_enable, res_start}, 0);
    chk({tag, "_max_reset_n"}, max_reset_n, 0);
    chk({tag, "_stop_iter"}, {stop_reason, iteration}, 0);
    chk({tag, "_addr_data"}, {support_write_addr, support_write_data}, 0);
    chk({tag, "_command"}, smp_command, CMD_COMPUTE);
  endtask

  task automatic run(input bit ld, input int sp, input logic [31:0] thr, output int done_at, output int first_smp);
    int inj;
    compute_model(ld, sp, thr);
    cnt_max = 0; cnt_res = 0; cnt_smp = 0; cur_ip = 0; wr_log_n = 0;
    run_active = 1'b1;
    @(negedge clock);
    start = 1'b1; load_matrix = ld; sparsity = 8'(sp); threshold = thr;
    inj = $urandom_range(3, 8);
    done_at = -1;
    first_smp = -1;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clock);
      start = (c == inj && busy && !done) ? 1'b1 : 1'b0;
      if (smp_start && first_smp < 0) first_smp = c;
      if (done) begin done_at = c; break; end
      chk("busy_during_run", busy, 1);
    end
    start = 1'b0;
    if (done_at < 0) begin
      chk("done_timeout", 0, 1);
      do_reset(2);
    end
    @(negedge clock);
    run_active = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 64));
    if (r == 1) return {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
    return {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  initial begin
    int da, fs, r;
    logic [31:0] thr;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    chk("model_f2r_one", longint'(f2r(32'h3f800000) == 1.0), 1);
    chk("model_f2r_neg_two", longint'(f2r(32'hc0000000) == -2.0), 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 16; i++) begin tbl_loc[i] = 8'(i + 10); tbl_val[i] = 32'h3f800000; end
    tbl_loc[0] = 8'd5; tbl_loc[1] = 8'd17; tbl_loc[2] = 8'd200;
    run(1'b1, 3, 32'd0, da, fs);
    chk("t1_first_smp_latency", fs, 1);
    chk("t1_smp_count", cnt_smp, 4);
    chk("t1_max_count", cnt_max, 12);
    chk("t1_writes", wr_log_n, 3);
    chk("t1_write0", wr_log[0], 16'h0005);
    chk("t1_write1", wr_log[1], 16'h0111);
    chk("t1_write2", wr_log[2], 16'h02C8);

    for (int i = 0; i < 16; i++) tbl_loc[i] = 8'(i + 10);
    run(1'b0, 20, 32'd0, da, fs);
    chk("t2_model_iter", exp_iter, 8);
    chk("t2_res_count", cnt_res, 8);

    tbl_val[2] = 32'h00000010;
    run(1'b0, 5, 32'h00000020, da, fs);
    chk("t3_model_stop", exp_stop, 1);
    chk("t3_model_iter", exp_iter, 2);
    chk("t3_writes", wr_log_n, 2);
    tbl_val[2] = 32'h3f800000;

    tbl_loc[0] = 8'd9; tbl_loc[1] = 8'd9;
    run(1'b0, 4, 32'd0, da, fs);
    chk("t4_model_stop", exp_stop, 2);
    chk("t4_res_count", cnt_res, 1);

    run(1'b1, 0, 32'd0, da, fs);
    chk("t5_done_latency", da, 2);
    chk("t5_smp_count", cnt_smp, 0);

    // Abort in MAX_WAIT of iteration 1, then restart from a clean state.
    tbl_loc[0] = 8'd3; tbl_loc[1] = 8'd4; tbl_loc[2] = 8'd6;
    max_dmin = 6; max_dmax = 6;
    compute_model(1'b0, 3, 32'd0);
    cnt_max = 0; cnt_res = 0; cnt_smp = 0; cur_ip = 0; wr_log_n = 0;
    run_active = 1'b1;
    @(negedge clock);
    start = 1'b1; load_matrix = 1'b0; sparsity = 8'd3; threshold = 32'd0;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (cnt_max >= 5) break;
      @(negedge clock);
    end
    chk("t6_reached_iter1_max", cnt_max, 5);
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check_reset_values("t6_abort");
    run_active = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    exp_cmd_q.delete();
    exp_wr_q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (c % 4 == 0) chk("t6_no_done_after_abort", done, 0);
    end
    max_dmin = 1; max_dmax = 3;
    run(1'b0, 3, 32'd0, da, fs);
    chk("t6_restart_writes", wr_log_n, 3);
    chk("t6_restart_write0", wr_log[0], 16'h0003);

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 16; i++) begin
        tbl_val[i] = rand_val();
        if ($urandom_range(0, 3) == 0) tbl_loc[i] = 8'($urandom_range(0, 3));
        else tbl_loc[i] = 8'($urandom_range(0, 255));
      end
      r = $urandom_range(0, 2);
      if (r == 0) thr = 32'd0;
      else if (r == 1) thr = {1'b0, 8'($urandom_range(110, 125)), 23'($urandom)};
      else thr = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
      run(1'($urandom_range(0, 1)), $urandom_range(0, 12), thr, da, fs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
